// File: rtl/sram_pkg.sv
// sram_pkg: state type and default geometry shared by the data-memory SRAM backend,
// the memory stage and the bench.
package sram_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sram_state_t;

  localparam int SRAM_DW = 16;
  localparam int DEF_SRAM_AW = 18;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// sram_controller: services one 32-bit load/store as two 16-bit async SRAM accesses.
// Optional one-entry last-write forwarding is enabled by defining SRAM_LAST_WRITE_FWD_EN.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned SRAM_WAIT = 1,
  parameter int unsigned SRAM_AW   = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int WW = SRAM_AW - 1;
  localparam logic [2:0] WAIT_LAST = 3'(SRAM_WAIT);

  sram_state_t state, state_n;
  logic [2:0]    wcnt, wcnt_n;
  logic          op_wr;
  logic [WW-1:0] word_q;
  logic [31:0]   data_q;

  logic [31:0]   off;
  logic [WW-1:0] word_in;
  logic          req;
  logic          fwd_hit;
  logic          unused_off;

  logic          nxt_wr;
  logic [WW-1:0] nxt_word;
  logic [31:0]   nxt_data;
  logic          nxt_in_phase;

  assign off        = address - BASE_ADDR;
  assign word_in    = off[SRAM_AW:2];
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
  assign req        = rd_en | wr_en;

  assign ready     = (state == IDLE) ? !req : (state == DONE);
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

`ifdef SRAM_LAST_WRITE_FWD_EN
  logic          fwd_valid;
  logic [WW-1:0] fwd_word;
  logic [31:0]   fwd_data;

  assign fwd_hit = fwd_valid && rd_en && !wr_en && (word_in == fwd_word);

  // The entry tracks the most recent write once it has fully reached the SRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_word  <= '0;
      fwd_data  <= '0;
    end else if (state == DONE && op_wr) begin
      fwd_valid <= 1'b1;
      fwd_word  <= word_q;
      fwd_data  <= data_q;
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    wcnt_n  = '0;
    case (state)
      IDLE: if (req) state_n = fwd_hit ? DONE : LOW;
      LOW: begin
        if (wcnt == WAIT_LAST) state_n = HIGH;
        else wcnt_n = wcnt + 3'd1;
      end
      HIGH: begin
        if (wcnt == WAIT_LAST) state_n = DONE;
        else wcnt_n = wcnt + 3'd1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Values the next cycle will drive: taken straight from the inputs on the capture edge.
  always_comb begin
    nxt_wr       = (state == IDLE) ? wr_en      : op_wr;
    nxt_word     = (state == IDLE) ? word_in    : word_q;
    nxt_data     = (state == IDLE) ? write_data : data_q;
    nxt_in_phase = (state_n == LOW) || (state_n == HIGH);
  end

  // we_n rises at the start of each phase's last cycle so the SRAM latches while address
  // and data are still held (a write pulse therefore needs SRAM_WAIT >= 1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      op_wr       <= 1'b0;
      word_q      <= '0;
      data_q      <= '0;
      read_data   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (state == IDLE && req) begin
        op_wr  <= wr_en;
        word_q <= word_in;
        data_q <= write_data;
      end
      sram_we_n  <= !(nxt_wr && nxt_in_phase && (wcnt_n < WAIT_LAST));
      sram_dq_oe <= nxt_wr && nxt_in_phase;
      if (nxt_in_phase) begin
        sram_addr   <= {nxt_word, state_n == HIGH};
        sram_dq_out <= (state_n == HIGH) ? nxt_data[31:16] : nxt_data[15:0];
      end
      if (!op_wr && wcnt == WAIT_LAST) begin
        if (state == LOW) read_data[15:0] <= sram_dq_in;
        else if (state == HIGH) read_data[31:16] <= sram_dq_in;
      end
`ifdef SRAM_LAST_WRITE_FWD_EN
      if (state == IDLE && fwd_hit) read_data <= fwd_data;
`endif
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: table-driven checks of sram_controller against a behavioral async SRAM
// whose writes commit on the rising edge of sram_we_n.
`timescale 1ns/1ps
module tb_sram_controller;
  import sram_pkg::*;

  localparam int W      = 1;
  localparam int FREEZE = 2 * W + 3;
  localparam int AW     = DEF_SRAM_AW;
`ifdef SRAM_LAST_WRITE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, wr_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(DEF_BASE_ADDR), .SRAM_WAIT(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  // Behavioral SRAM: async read; address/data latched while we_n is low, committed on its
  // rising edge. A rise caused by reset is an aborted write and commits nothing.
  logic [15:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] wa;
  logic [15:0]   wd;
  assign sram_dq_in = mem[sram_addr];
  always @(sram_we_n or sram_addr or sram_dq_out)
    if (!sram_we_n) begin
      wa = sram_addr;
      wd = sram_dq_out;
    end
  always @(posedge sram_we_n)
    if (!rst) mem[wa] = wd;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [AW-1:0] exp_lo_addr;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t vecs[10];

  bit            fv_valid = 1'b0;
  logic [AW-2:0] fv_word  = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit scramble);
    int            cyc;
    bit            done;
    bit            hit;
    bit            saw_oe;
    logic [AW-1:0] a_lo, a_hi, addr_before;
    hit = FWD_EN && fv_valid && v.rd && !v.wr && (v.exp_lo_addr[AW-1:1] == fv_word);
    @(posedge clk); #1;
    addr_before = sram_addr;
    rd_en = v.rd; wr_en = v.wr; address = v.addr; write_data = v.wdata;
    cyc = 0; done = 0; saw_oe = 0; a_lo = '0; a_hi = '0;
    #1;
    while (!done && cyc < 40) begin
      if (sram_dq_oe) saw_oe = 1;
      if (cyc == 1) a_lo = sram_addr;
      if (cyc == W + 2) a_hi = sram_addr;
      if (ready) done = 1;
      else begin
        @(posedge clk); #2;
        cyc++;
        if (scramble && cyc == 1) begin
          address = DEF_BASE_ADDR;
          write_data = 32'hFFFF_FFFF;
        end
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("[TB] FAIL timeout: ready never returned for address 0x%08h", v.addr);
    end
    checkOutput("freeze_cycles", 32'(cyc), hit ? 32'd1 : 32'(FREEZE));
    checkOutput("dq_oe_seen", 32'(saw_oe), 32'(v.wr));
    if (v.rd && !v.wr) checkOutput("read_data", read_data, v.exp_rdata);
    if (hit) checkOutput("addr_unchanged", 32'(sram_addr), 32'(addr_before));
    else begin
      checkOutput("addr_low", 32'(a_lo), 32'(v.exp_lo_addr));
      checkOutput("addr_high", 32'(a_hi), 32'(v.exp_lo_addr | 1));
    end
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
    if (v.wr) begin
      checkOutput("mem_low", 32'(mem[v.exp_lo_addr]), 32'(v.wdata[15:0]));
      checkOutput("mem_high", 32'(mem[v.exp_lo_addr | 1]), 32'(v.wdata[31:16]));
      fv_valid = 1;
      fv_word  = v.exp_lo_addr[AW-1:1];
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    mem[12] = 16'hAAAA;
    mem[13] = 16'h5555;

    vecs[0] = '{wr:1'b1, rd:1'b0, addr:32'd1032,     wdata:32'hDEADBEEF, exp_lo_addr:18'd4,      exp_rdata:32'h0};
    vecs[1] = '{wr:1'b0, rd:1'b1, addr:32'd1032,     wdata:32'h0,        exp_lo_addr:18'd4,      exp_rdata:32'hDEADBEEF};
    vecs[2] = '{wr:1'b1, rd:1'b1, addr:32'd1024,     wdata:32'h12345678, exp_lo_addr:18'd0,      exp_rdata:32'h0};
    vecs[3] = '{wr:1'b0, rd:1'b1, addr:32'd1024,     wdata:32'h0,        exp_lo_addr:18'd0,      exp_rdata:32'h12345678};
    vecs[4] = '{wr:1'b1, rd:1'b0, addr:32'd1040,     wdata:32'hCAFEF00D, exp_lo_addr:18'd8,      exp_rdata:32'h0};
    vecs[5] = '{wr:1'b0, rd:1'b1, addr:32'd1040,     wdata:32'h0,        exp_lo_addr:18'd8,      exp_rdata:32'hCAFEF00D};
    vecs[6] = '{wr:1'b0, rd:1'b1, addr:32'd1034,     wdata:32'h0,        exp_lo_addr:18'd4,      exp_rdata:32'hDEADBEEF};
    vecs[7] = '{wr:1'b0, rd:1'b1, addr:32'd1048,     wdata:32'h0,        exp_lo_addr:18'd12,     exp_rdata:32'h5555AAAA};
    vecs[8] = '{wr:1'b1, rd:1'b0, addr:32'h000803FC, wdata:32'h0BADF00D, exp_lo_addr:18'h3FFFE, exp_rdata:32'h0};
    vecs[9] = '{wr:1'b0, rd:1'b1, addr:32'h000803FC, wdata:32'h0,        exp_lo_addr:18'h3FFFE, exp_rdata:32'h0BADF00D};

    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("reset_read_data", read_data, 32'd0);
    checkOutput("reset_sram_addr", 32'(sram_addr), 32'd0);
    checkOutput("tied_controls", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'd0);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], 1'b0);

    // Inputs changing after capture must not disturb the write in flight.
    applyStimulus('{wr:1'b1, rd:1'b0, addr:32'd1064, wdata:32'h13572468,
                    exp_lo_addr:18'd20, exp_rdata:32'h0}, 1'b1);
    checkOutput("no_stray_low", 32'(mem[0]), 32'h5678);
    checkOutput("no_stray_high", 32'(mem[1]), 32'h1234);

    // Reset during the first HIGH cycle of a store aborts the high half.
    @(posedge clk); #1;
    wr_en = 1; address = 32'd1056; write_data = 32'h77778888;
    repeat (W + 2) @(posedge clk);
    #1;
    checkOutput("high_phase_we_n", 32'(sram_we_n), 32'd0);
    checkOutput("high_phase_addr", 32'(sram_addr), 32'd17);
    rst = 1; wr_en = 0;
    @(posedge clk); #1;
    rst = 0;
    #1;
    checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("abort_read_data", read_data, 32'd0);
    checkOutput("abort_sram_addr", 32'(sram_addr), 32'd0);
    checkOutput("abort_mem_low", 32'(mem[16]), 32'h8888);
    checkOutput("abort_mem_high", 32'(mem[17]), 32'h0000);
    fv_valid = 0;

    applyStimulus(vecs[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
